// File: rtl/barrett_pkg.sv
// Shared widths, types and helpers for the streaming Barrett reducer.
package barrett_pkg;

   localparam int DW       = 48;
   localparam int QW       = 23;
   localparam int TW       = 8;
   localparam int MU_WIDTH = DW + 1;

   localparam int unsigned KYBER_Q     = 3329;
   localparam int unsigned DILITHIUM_Q = 8380417;
   localparam int unsigned NTRU_Q      = 4591;

   typedef enum logic {IDLE, DIV} cfg_state_t;

   typedef struct packed {
      logic          valid;
      logic [DW-1:0] x;
      logic [TW-1:0] tag;
   } s1_t;

   // r0 < 2q, so only the low QW+1 bits of x and qhat ever matter
   typedef struct packed {
      logic          valid;
      logic [QW:0]   x_lo;
      logic [TW-1:0] tag;
      logic [QW:0]   qhat;
   } s2_t;

   typedef struct packed {
      logic          valid;
      logic [TW-1:0] tag;
      logic [QW:0]   r0;
   } res_t;

   function automatic logic [QW:0] qhat_lo(
      input logic [DW-1:0]       x,
      input logic [MU_WIDTH-1:0] mu
   );
      logic [DW+MU_WIDTH-1:0] p;
      p = (DW+MU_WIDTH)'(x) * (DW+MU_WIDTH)'(mu);
      return p[DW +: QW+1];
   endfunction

endpackage

// File: rtl/barrett_mu_div.sv
// Restoring divider producing mu = floor(2^DW / q), one quotient bit per cycle.
module barrett_mu_div
   import barrett_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [QW-1:0]       q,
   output logic                busy,
   output logic                done,
   output logic [MU_WIDTH-1:0] mu
);

   localparam int CW = $clog2(MU_WIDTH + 1);

   logic                busy_q, busy_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [QW-1:0]       rem_q, rem_d;
   logic [QW-1:0]       dv_q, dv_d;
   logic [MU_WIDTH-2:0] quo_q, quo_d;
   logic [QW:0]         trial;
   logic                qb;

   // dividend is a single 1 followed by DW zeros
   assign trial = {rem_q, (cnt_q == CW'(DW))};
   assign qb    = (trial >= {1'b0, dv_q});

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      dv_d   = dv_q;
      quo_d  = quo_q;
      if (busy_q) begin
         rem_d = qb ? QW'(trial - {1'b0, dv_q}) : trial[QW-1:0];
         quo_d = {quo_q[MU_WIDTH-3:0], qb};
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == '0) begin
            busy_d = 1'b0;
         end
      end else if (start) begin
         busy_d = 1'b1;
         cnt_d  = CW'(DW);
         rem_d  = '0;
         quo_d  = '0;
         dv_d   = q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         dv_q   <= '0;
         quo_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         dv_q   <= dv_d;
         quo_q  <= quo_d;
      end
   end

   assign busy = busy_q;
   assign done = busy_q & (cnt_q == '0);
   assign mu   = {quo_q, qb};

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Streaming x mod q reducer: 4-stage Barrett pipe with runtime modulus load.
module barrett_reduce_pipe
   import barrett_pkg::*;
#(
   parameter int DATA_WIDTH = DW,
   parameter int Q_WIDTH    = QW,
   parameter int TAG_WIDTH  = TW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   input  logic [Q_WIDTH-1:0]    cfg_q,
   output logic                  cfg_ready,
   output logic                  cfg_err,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [Q_WIDTH-1:0]    out_data,
   output logic [TAG_WIDTH-1:0]  out_tag,
   input  logic                  out_ready
);

   if (DATA_WIDTH < Q_WIDTH) begin : g_bad_width
      $fatal(1, "DATA_WIDTH must be >= Q_WIDTH");
   end
   if (DATA_WIDTH != DW || Q_WIDTH != QW || TAG_WIDTH != TW) begin : g_bad_pkg
      $fatal(1, "parameters must match barrett_pkg widths");
   end

   cfg_state_t          state_q, state_d;
   logic                mod_ok_q, mod_ok_d;
   logic                err_q, err_d;
   logic [QW-1:0]       q_q, q_d, qp_q, qp_d;
   logic [MU_WIDTH-1:0] mu_q, mu_d;
   s1_t                 s1_q, s1_d;
   s2_t                 s2_q, s2_d;
   res_t                s3_q, s3_d;
   logic                ov_q, ov_d;
   logic [QW-1:0]       od_q, od_d;
   logic [TW-1:0]       ot_q, ot_d;

   logic                en, fire, empty, cfg_fire;
   logic                div_start, div_busy, div_done;
   logic [MU_WIDTH-1:0] div_mu;

   assign en        = !ov_q | out_ready;
   assign in_ready  = mod_ok_q & (state_q == IDLE) & en;
   assign fire      = in_valid & in_ready;
   assign empty     = !(s1_q.valid | s2_q.valid | s3_q.valid | ov_q);
   assign cfg_ready = (state_q == IDLE) & !div_busy & empty & !fire;
   assign cfg_fire  = cfg_valid & cfg_ready;

   barrett_mu_div u_div (
      .clk   (clk),
      .rst   (rst),
      .start (div_start),
      .q     (cfg_q),
      .busy  (div_busy),
      .done  (div_done),
      .mu    (div_mu)
   );

   always_comb begin
      state_d   = state_q;
      mod_ok_d  = mod_ok_q;
      err_d     = err_q;
      q_d       = q_q;
      qp_d      = qp_q;
      mu_d      = mu_q;
      div_start = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cfg_fire) begin
               mod_ok_d = 1'b0;
               if (cfg_q < QW'(2)) begin
                  err_d = 1'b1;
               end else begin
                  err_d     = 1'b0;
                  qp_d      = cfg_q;
                  div_start = 1'b1;
                  state_d   = DIV;
               end
            end
         end
         DIV: begin
            if (div_done) begin
               mu_d     = div_mu;
               q_d      = qp_q;
               mod_ok_d = 1'b1;
               state_d  = IDLE;
            end
         end
      endcase
   end

   always_comb begin
      s1_d = s1_q;
      s2_d = s2_q;
      s3_d = s3_q;
      ov_d = ov_q;
      od_d = od_q;
      ot_d = ot_q;
      if (en) begin
         s1_d.valid = fire;
         s1_d.x     = in_data;
         s1_d.tag   = in_tag;
         s2_d.valid = s1_q.valid;
         s2_d.x_lo  = s1_q.x[QW:0];
         s2_d.tag   = s1_q.tag;
         s2_d.qhat  = qhat_lo(s1_q.x, mu_q);
         s3_d.valid = s2_q.valid;
         s3_d.tag   = s2_q.tag;
         s3_d.r0    = s2_q.x_lo - s2_q.qhat * {1'b0, q_q};
         ov_d       = s3_q.valid;
         ot_d       = s3_q.tag;
         od_d       = (s3_q.r0 >= {1'b0, q_q})
                    ? QW'(s3_q.r0 - {1'b0, q_q})
                    : s3_q.r0[QW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mod_ok_q <= 1'b0;
         err_q    <= 1'b0;
         q_q      <= '0;
         qp_q     <= '0;
         mu_q     <= '0;
         s1_q     <= '0;
         s2_q     <= '0;
         s3_q     <= '0;
         ov_q     <= 1'b0;
         od_q     <= '0;
         ot_q     <= '0;
      end else begin
         state_q  <= state_d;
         mod_ok_q <= mod_ok_d;
         err_q    <= err_d;
         q_q      <= q_d;
         qp_q     <= qp_d;
         mu_q     <= mu_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         s3_q     <= s3_d;
         ov_q     <= ov_d;
         od_q     <= od_d;
         ot_q     <= ot_d;
      end
   end

   assign cfg_err   = err_q;
   assign out_valid = ov_q;
   assign out_data  = od_q;
   assign out_tag   = ot_q;

endmodule
